// File: rtl/branch_ctrl.sv
// Control-transfer sequencer for the execute stage: resolves branch/JAL/JALR through
// the shared comparator, redirects fetch, flushes younger stages, or raises a trap.
module branch_ctrl #(
    parameter int XLEN         = 32,
    parameter int FLUSH_CYCLES = 2
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            br_valid,
    output logic            br_ready,
    input  logic [1:0]      br_kind,
    input  logic [2:0]      br_funct3,
    input  logic [XLEN-1:0] br_pc,
    input  logic [XLEN-1:0] br_imm,
    input  logic [XLEN-1:0] br_rs1,
    input  logic [XLEN-1:0] br_rs2,
    output logic [XLEN-1:0] cmp_x,
    output logic [XLEN-1:0] cmp_y,
    output logic [2:0]      cmp_funct3,
    input  logic            cmp_out,
    output logic            redirect_valid,
    input  logic            redirect_ready,
    output logic [XLEN-1:0] redirect_pc,
    output logic            flush,
    output logic            link_valid,
    output logic [XLEN-1:0] link_data,
    output logic            exc_valid,
    output logic            exc_cause,
    output logic [XLEN-1:0] exc_tval,
    output logic            busy
);

    // state    | meaning
    // IDLE     | waiting for an op, br_ready high
    // RESOLVE  | comparator settles on registered operands, outcome decided
    // REDIRECT | redirect_valid held until fetch accepts
    // FLUSH    | flush asserted while the counter runs down
    // EXC      | one-cycle exception pulse to the trap unit
    typedef enum logic [2:0] {
        S_IDLE,
        S_RESOLVE,
        S_REDIRECT,
        S_FLUSH,
        S_EXC
    } state_t;

    localparam int CW = (FLUSH_CYCLES > 0) ? $clog2(FLUSH_CYCLES + 1) : 1;
    localparam logic [1:0] K_BRANCH = 2'b00;
    localparam logic [1:0] K_JALR   = 2'b10;
    localparam logic [1:0] K_RSVD   = 2'b11;

    state_t          state, state_d;
    logic [CW-1:0]   cnt, cnt_d;
    logic [1:0]      kind, kind_d;
    logic [XLEN-1:0] pc, pc_d, imm, imm_d;

    logic [XLEN-1:0] cmp_x_d, cmp_y_d, redirect_pc_d, link_data_d, exc_tval_d;
    logic [2:0]      cmp_funct3_d;
    logic            redirect_valid_d, flush_d, link_valid_d, exc_valid_d, exc_cause_d;

    logic            taken, illegal, misaligned;
    logic [XLEN-1:0] jalr_sum, target;

    // Outcome of the op currently held in the operand registers.
    always_comb begin
        illegal    = (kind == K_RSVD) || ((kind == K_BRANCH) && (cmp_funct3[2:1] == 2'b01));
        taken      = (kind == K_BRANCH) ? cmp_out : 1'b1;
        jalr_sum   = cmp_x + imm;
        target     = (kind == K_JALR) ? {jalr_sum[XLEN-1:1], 1'b0} : pc + imm;
        misaligned = taken && target[1];
    end

    always_comb begin
        state_d          = state;
        cnt_d            = cnt;
        kind_d           = kind;
        pc_d             = pc;
        imm_d            = imm;
        cmp_x_d          = cmp_x;
        cmp_y_d          = cmp_y;
        cmp_funct3_d     = cmp_funct3;
        redirect_valid_d = redirect_valid;
        redirect_pc_d    = redirect_pc;
        flush_d          = 1'b0;
        link_valid_d     = 1'b0;
        link_data_d      = link_data;
        exc_valid_d      = 1'b0;
        exc_cause_d      = exc_cause;
        exc_tval_d       = exc_tval;

        case (state)
            S_IDLE: begin
                if (br_valid) begin
                    kind_d       = br_kind;
                    pc_d         = br_pc;
                    imm_d        = br_imm;
                    cmp_x_d      = br_rs1;
                    cmp_y_d      = br_rs2;
                    cmp_funct3_d = br_funct3;
                    state_d      = S_RESOLVE;
                end
            end
            S_RESOLVE: begin
                if (illegal) begin
                    exc_valid_d = 1'b1;
                    exc_cause_d = 1'b1;
                    exc_tval_d  = '0;
                    state_d     = S_EXC;
                end else if (misaligned) begin
                    exc_valid_d = 1'b1;
                    exc_cause_d = 1'b0;
                    exc_tval_d  = target;
                    state_d     = S_EXC;
                end else if (taken) begin
                    redirect_valid_d = 1'b1;
                    redirect_pc_d    = target;
                    link_valid_d     = (kind != K_BRANCH);
                    link_data_d      = pc + XLEN'(4);
                    state_d          = S_REDIRECT;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_REDIRECT: begin
                if (redirect_ready) begin
                    redirect_valid_d = 1'b0;
                    if (FLUSH_CYCLES == 0) begin
                        state_d = S_IDLE;
                    end else begin
                        flush_d = 1'b1;
                        cnt_d   = CW'(FLUSH_CYCLES);
                        state_d = S_FLUSH;
                    end
                end
            end
            S_FLUSH: begin
                if (cnt == CW'(1)) begin
                    state_d = S_IDLE;
                end else begin
                    flush_d = 1'b1;
                    cnt_d   = cnt - CW'(1);
                end
            end
            S_EXC: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state          <= S_IDLE;
            cnt            <= '0;
            kind           <= '0;
            pc             <= '0;
            imm            <= '0;
            cmp_x          <= '0;
            cmp_y          <= '0;
            cmp_funct3     <= '0;
            redirect_valid <= 1'b0;
            redirect_pc    <= '0;
            flush          <= 1'b0;
            link_valid     <= 1'b0;
            link_data      <= '0;
            exc_valid      <= 1'b0;
            exc_cause      <= 1'b0;
            exc_tval       <= '0;
        end else begin
            state          <= state_d;
            cnt            <= cnt_d;
            kind           <= kind_d;
            pc             <= pc_d;
            imm            <= imm_d;
            cmp_x          <= cmp_x_d;
            cmp_y          <= cmp_y_d;
            cmp_funct3     <= cmp_funct3_d;
            redirect_valid <= redirect_valid_d;
            redirect_pc    <= redirect_pc_d;
            flush          <= flush_d;
            link_valid     <= link_valid_d;
            link_data      <= link_data_d;
            exc_valid      <= exc_valid_d;
            exc_cause      <= exc_cause_d;
            exc_tval       <= exc_tval_d;
        end
    end

    // br_ready stays low while reset is held so nothing is accepted mid-reset.
    assign br_ready = (state == S_IDLE) && !rst;
    assign busy     = (state != S_IDLE);

endmodule
